// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared state encoding, default parameters and widths for the reset sequencer.
package rst_seq_pkg;
    localparam logic [1:0] HOLD    = 2'd0;
    localparam logic [1:0] RELEASE = 2'd1;
    localparam logic [1:0] RUN     = 2'd2;
    localparam int DEF_N_STAGES    = 3;
    localparam int DEF_HOLD_CYCLES = 4;
    localparam int DEF_GAP_CYCLES  = 2;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_WDOG_CYCLES = 64;
    localparam int RCNT_W          = 8;
endpackage

// File: rtl/rst_seq_cnt.sv
// rst_seq_cnt: free-running up-counter with synchronous clear and terminal-count compare.
module rst_seq_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [W-1:0] tc_val,
    output logic         tc
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr ? '0 : cnt_q + W'(1);
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign tc = cnt_q == tc_val;
endmodule

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: staged reset sequencer with soft-reset handshake.
// Optional watchdog restart enabled by defining RST_SEQ_WDOG_EN.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int N_STAGES    = DEF_N_STAGES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                soft_rst_req,
    output logic                soft_rst_ack,
    output logic [N_STAGES-1:0] stage_rst_o,
    output logic                all_released,
    output logic [RCNT_W-1:0]   rst_count,
    input  logic                wdog_kick,
    output logic                wdog_fired
);
    localparam int IW = N_STAGES > 1 ? $clog2(N_STAGES) : 1;
    logic [1:0] state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [N_STAGES-1:0] stage_q, stage_d;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic all_q, all_d, ack_q, ack_d, fired_q, fired_d;
    logic tc, last, step, restart, wdog_to;
    assign last    = idx_q == IW'(N_STAGES - 1);
    assign step    = state_q != RUN && tc;
    assign restart = soft_rst_req || wdog_to;
    // One counter times both the initial hold and each inter-stage gap; it reloads on every stage change.
    rst_seq_cnt #(.W(CNT_W)) u_hold (
        .clk    (clk),
        .rst    (rst),
        .clr    (restart || step || state_q == RUN),
        .tc_val (state_q == HOLD ? CNT_W'(HOLD_CYCLES - 1) : CNT_W'(GAP_CYCLES - 1)),
        .tc     (tc)
    );
`ifdef RST_SEQ_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES) + 1;
    logic wtc;
    rst_seq_cnt #(.W(WW)) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_q != RUN || wdog_kick || restart),
        .tc_val (WW'(WDOG_CYCLES - 1)),
        .tc     (wtc)
    );
    assign wdog_to = state_q == RUN && !wdog_kick && wtc;
`else
    localparam int unused_wdog_cycles = WDOG_CYCLES;
    logic unused_kick;
    assign unused_kick = wdog_kick;
    assign wdog_to = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) state_q <= HOLD;
        else state_q <= state_d;
    end
    always_comb state_d = restart ? HOLD : step ? (last ? RUN : RELEASE) : state_q;
    always_comb begin
        stage_d = restart ? '1 : step ? stage_q & ~(N_STAGES'(1) << idx_q) : stage_q;
        idx_d   = restart ? '0 : (step && !last) ? idx_q + IW'(1) : idx_q;
        all_d   = !restart && (all_q || (step && last));
        ack_d   = soft_rst_req;
        rcnt_d  = (restart && rcnt_q != '1) ? rcnt_q + RCNT_W'(1) : rcnt_q;
        fired_d = fired_q || wdog_to;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            stage_q <= '1;
            all_q   <= 1'b0;
            ack_q   <= 1'b0;
            rcnt_q  <= '0;
            fired_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            stage_q <= stage_d;
            all_q   <= all_d;
            ack_q   <= ack_d;
            rcnt_q  <= rcnt_d;
            fired_q <= fired_d;
        end
    end
    assign stage_rst_o  = stage_q;
    assign all_released = all_q;
    assign soft_rst_ack = ack_q;
    assign rst_count    = rcnt_q;
    assign wdog_fired   = fired_q;
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: vector table, directed corner sequences and random stimulus against a timeline model.
module tb_rst_seq_ctrl;
    localparam int N = 3, H = 4, G = 2, W = 16, LAT = H + (N - 1) * G;
    logic clk = 1'b0, rst = 1'b1, soft_rst_req = 1'b0, wdog_kick = 1'b0;
    logic soft_rst_ack, all_released, wdog_fired;
    logic [N-1:0] stage_rst_o;
    logic [7:0] rst_count;
    int passed = 0, total = 0;
    int m_t = 0, m_cnt = 0, m_idle = 0;
    bit m_ack = 0, m_fired = 0;

    typedef struct {
        bit r;
        bit s;
        int st;
        bit al;
        bit ak;
        int ct;
    } vec_t;
    vec_t tv[$];

    always #5 clk = ~clk;

    rst_seq_ctrl #(
        .N_STAGES(N), .HOLD_CYCLES(H), .GAP_CYCLES(G), .CNT_W(8), .WDOG_CYCLES(W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .soft_rst_req (soft_rst_req),
        .soft_rst_ack (soft_rst_ack),
        .stage_rst_o  (stage_rst_o),
        .all_released (all_released),
        .rst_count    (rst_count),
        .wdog_kick    (wdog_kick),
        .wdog_fired   (wdog_fired)
    );

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    // Model: m_t is the number of edges since the sequence (re)started; stage k is free once m_t >= H + k*G.
    function automatic void model(input bit r, input bit s, input bit k);
        bit run, to;
        run = m_t >= LAT;
        to = 1'b0;
        if (r) begin
            m_t = 0; m_cnt = 0; m_fired = 0; m_idle = 0; m_ack = 0;
            return;
        end
`ifdef RST_SEQ_WDOG_EN
        to = run && !k && m_idle == W - 1;
`endif
        if (s || to) begin
            m_t = 0;
            m_ack = s;
            if (m_cnt < 255) m_cnt++;
            if (to) m_fired = 1;
            m_idle = 0;
        end else begin
            m_ack = 0;
            if (m_t < LAT) m_t++;
            m_idle = (run && !k) ? m_idle + 1 : 0;
        end
    endfunction

    function automatic int exp_stage();
        int v = 0;
        for (int k = 0; k < N; k++) if (m_t < H + k * G) v |= 1 << k;
        return v;
    endfunction

    task automatic step(input bit r, input bit s, input bit k);
        rst = r; soft_rst_req = s; wdog_kick = k;
        @(posedge clk);
        model(r, s, k);
        #1;
        chk("m_stage", int'(stage_rst_o), exp_stage());
        chk("m_all", int'(all_released), int'(m_t >= LAT));
        chk("m_ack", int'(soft_rst_ack), int'(m_ack));
        chk("m_count", int'(rst_count), m_cnt);
        chk("m_fired", int'(wdog_fired), int'(m_fired));
    endtask

    function automatic void add(input bit r, input bit s, input int st, input bit al, input bit ak, input int ct);
        vec_t v;
        v.r = r; v.s = s; v.st = st; v.al = al; v.ak = ak; v.ct = ct;
        tv.push_back(v);
    endfunction

    initial begin
        repeat (3) add(1, 0, 3'b111, 0, 0, 0);
        repeat (3) add(0, 0, 3'b111, 0, 0, 0);
        repeat (2) add(0, 0, 3'b110, 0, 0, 0);
        repeat (2) add(0, 0, 3'b100, 0, 0, 0);
        add(0, 0, 3'b000, 1, 0, 0);
        add(0, 1, 3'b111, 0, 1, 1);
        repeat (3) add(0, 0, 3'b111, 0, 0, 1);
        add(0, 0, 3'b110, 0, 0, 1);
        add(0, 1, 3'b111, 0, 1, 2);
        add(0, 0, 3'b111, 0, 0, 2);
        add(1, 1, 3'b111, 0, 0, 0);
        foreach (tv[i]) begin
            step(tv[i].r, tv[i].s, 1'b0);
            chk($sformatf("tv%0d_stage", i), int'(stage_rst_o), tv[i].st);
            chk($sformatf("tv%0d_all", i), int'(all_released), int'(tv[i].al));
            chk($sformatf("tv%0d_ack", i), int'(soft_rst_ack), int'(tv[i].ak));
            chk($sformatf("tv%0d_count", i), int'(rst_count), tv[i].ct);
        end
        repeat (10) step(0, 0, 0);
        chk("run_reached", int'(all_released), 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0);
            chk("held_ack", int'(soft_rst_ack), 1);
            chk("held_count", int'(rst_count), i + 1);
            chk("held_stage", int'(stage_rst_o), 7);
        end
        step(0, 0, 0);
        chk("held_ack_drop", int'(soft_rst_ack), 0);
        repeat (2) begin
            step(0, 1, 0);
            repeat (9) step(0, 0, 0);
        end
        chk("count_five", int'(rst_count), 5);
        step(1, 0, 0);
        chk("midrst_count", int'(rst_count), 0);
        chk("midrst_stage", int'(stage_rst_o), 7);
        chk("midrst_all", int'(all_released), 0);
        chk("midrst_fired", int'(wdog_fired), 0);
        repeat (LAT) step(0, 0, 0);
        chk("midrst_rerun", int'(all_released), 1);
        repeat (W + 4) step(0, 0, 0);
`ifdef RST_SEQ_WDOG_EN
        chk("wdog_fired_idle", int'(wdog_fired), 1);
        chk("wdog_no_ack", int'(rst_count), 1);
`else
        chk("wdog_fired_idle", int'(wdog_fired), 0);
        chk("wdog_no_restart", int'(rst_count), 0);
`endif
        step(1, 0, 0);
        repeat (LAT) step(0, 0, 0);
        for (int i = 0; i < 4 * W; i++) step(0, 0, i % 10 == 9);
        chk("kicked_fired", int'(wdog_fired), 0);
        chk("kicked_run", int'(all_released), 1);
        for (int i = 0; i < 300; i++) begin
            step(0, 1, 0);
            repeat (19) step(0, 0, 0);
        end
        chk("saturate", int'(rst_count), 255);
        step(0, 1, 0);
        chk("saturate_hold", int'(rst_count), 255);
        chk("saturate_ack", int'(soft_rst_ack), 1);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
